ce_sched: RTL
=============

// Module: ce_sched
// PURPOSE
//  Sequencer for one convolution-element (CE) datapath. Runs a layer pass output channel by
//  output channel: requests the channel's weight set, streams cfg_pix input windows into the CE,
//  then drains the CE pipeline. Tags every CE result with its channel/pixel index.
//  Sits between the window line-buffer, the weight memory and the CE instance.
// PARAMETERS
//  OCH_W  = 6  width of output-channel count/index (max 2**OCH_W-1 channels)
//  PIX_W  = 12 width of pixel count/index per channel
//  WLAT   = 2  weight-memory read latency, cycles (>=1)
//  CE_LAT = 4  CE input-to-output latency; used only for outstanding-counter sizing
// PORTS
//  clk        in  1      clock
//  rst        in  1      synchronous reset, active-high
//  start      in  1      1-cycle pulse; starts a pass; ignored unless IDLE
//  cfg_och    in  OCH_W  number of output channels; sampled on accepted start
//  cfg_pix    in  PIX_W  windows per channel; sampled on accepted start
//  w_rd       out 1      1-cycle weight-set read request
//  w_addr     out OCH_W  weight-set index; valid with w_rd
//  w_load     out 1      CE weight register load strobe, WLAT cycles after w_rd
//  win_valid  in  1      line-buffer window available
//  win_ready  out 1      window consumed this cycle
//  ce_en_in   out 1      CE en_in; equals win_valid & win_ready
//  ce_en_out  in  1      CE en_out (result valid)
//  res_valid  out 1      equals ce_en_out, qualified with the tags
//  res_och    out OCH_W  output-channel tag of the current result
//  res_pix    out PIX_W  pixel tag of the current result
//  busy       out 1      high in every state except IDLE
//  done       out 1      1-cycle pulse at end of pass
//  err        out 1      sticky: ce_en_out seen while outstanding==0
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; counters and err cleared. Reset mid-pass aborts at once;
//   in-flight CE results after reset are not tagged and do not set err.
//  FSM: IDLE -start & cfg_och!=0 & cfg_pix!=0-> WREQ; start with a zero cfg -> done pulse, stay IDLE.
//   WREQ: w_rd=1 and w_addr=och_cnt for 1 cycle -> WWAIT.
//   WWAIT: WLAT-1 cycles, then w_load=1 for 1 cycle -> RUN.
//   RUN: win_ready=1; each win_valid cycle issues one window (pix_cnt++).
//    After cfg_pix issues -> DRAIN (win_ready=0 from that cycle).
//   DRAIN: wait until outstanding==0; then if och_cnt==cfg_och-1 -> DONE, else och_cnt++ -> WREQ.
//   DONE: done=1 for 1 cycle -> IDLE.
//  Weights never change while a window of the previous channel is in flight (DRAIN guarantees this).
//  outstanding: +1 per ce_en_in, -1 per ce_en_out; both in one cycle -> unchanged.
//   Width is clog2(CE_LAT+2).
//  Tags: res_pix counts ce_en_out pulses in 0..cfg_pix-1, wraps to 0, then res_och++.
//   res_och/res_pix are valid combinationally with res_valid and advance the cycle after.
//  err: set on ce_en_out while outstanding==0 and not (ce_en_in in the same cycle); cleared only by rst.
//  start while busy: ignored, no effect on cfg.
//  Throughput: 1 window/cycle in RUN; per-channel overhead is 1+WLAT cycles + drain (~CE_LAT).
// CONFIGURATION
//  CE_SCHED_PERF_EN defined: adds output port stall_cnt [31:0], the count of RUN cycles with
//   win_valid==0. It is cleared on an accepted start, saturates at 2**32-1, and holds after done.
//  Not defined: the port and its counter are absent. All other behaviour is identical.
// TESTING
//  T1 reset: hold rst 3 cycles mid-RUN -> busy=0, win_ready=0, err=0, next start works normally.
//  T2 basic: cfg_och=2, cfg_pix=4, win_valid=1 always, CE model lat 4 ->
//     w_addr 0 then 1; 8 ce_en_in; tags (0,0..3),(1,0..3); single done pulse.
//  T3 backpressure: win_valid random 50% -> exactly cfg_pix issues per channel;
//     no ce_en_in outside RUN; w_load never while outstanding!=0.
//  T4 corner: cfg_pix=1, cfg_och=1 -> one w_rd, one window, done after drain;
//     cfg_och=0 -> done pulse next cycle, no w_rd.
//  T5 error: inject ce_en_out in IDLE -> err=1 and stays 1 until rst.
//  T6 perf (CE_SCHED_PERF_EN): cfg_och=1, cfg_pix=4, win_valid low for 3 RUN cycles ->
//     stall_cnt=3 at done.

Source files
------------

// File: rtl/ce_sched.sv
// Convolution-element pass sequencer: per output channel, fetch weights, stream windows, drain, tag results.
// Optional macro CE_SCHED_PERF_EN adds the stall_cnt_o performance counter port.
module ce_sched #(
   parameter int OCH_W  = 6,
   parameter int PIX_W  = 12,
   parameter int WLAT   = 2,
   parameter int CE_LAT = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [OCH_W-1:0] cfg_och_i,
   input  logic [PIX_W-1:0] cfg_pix_i,
   output logic             w_rd_o,
   output logic [OCH_W-1:0] w_addr_o,
   output logic             w_load_o,
   input  logic             win_valid_i,
   output logic             win_ready_o,
   output logic             ce_en_in_o,
   input  logic             ce_en_out_i,
   output logic             res_valid_o,
   output logic [OCH_W-1:0] res_och_o,
   output logic [PIX_W-1:0] res_pix_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
`ifdef CE_SCHED_PERF_EN
   ,
   output logic [31:0]      stall_cnt_o
`endif
);

   localparam int OUT_W = $clog2(CE_LAT + 2);
   localparam int WC_W  = $clog2(WLAT + 1);
   localparam int FL_W  = $clog2(CE_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WREQ,
      S_WWAIT,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [OCH_W-1:0] och_q, och_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic [WC_W-1:0]  wait_q, wait_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic [FL_W-1:0]  flush_q;
   logic [OCH_W-1:0] res_och_q;
   logic [PIX_W-1:0] res_pix_q;
   logic             err_q;
   logic             zdone_q;
   logic [OCH_W-1:0] cfg_och_q;
   logic [PIX_W-1:0] cfg_pix_q;

   logic accept;
   logic cfg_zero;
   logic ce_in;
   logic ce_out_ok;
   logic run_st;

   assign accept    = (state_q == S_IDLE) && start_i;
   assign cfg_zero  = (cfg_och_i == '0) || (cfg_pix_i == '0);
   assign run_st    = (state_q == S_RUN);
   assign ce_in     = win_valid_i && run_st;
   // Results still in the CE from before a reset are ignored until the pipeline has flushed.
   assign ce_out_ok = ce_en_out_i && !rst_i && (flush_q == '0);

   always_comb begin
      state_d  = state_q;
      och_d    = och_q;
      pix_d    = pix_q;
      wait_d   = wait_q;
      w_rd_o   = 1'b0;
      w_load_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && !cfg_zero) begin
               state_d = S_WREQ;
               och_d   = '0;
               pix_d   = '0;
            end
         end
         S_WREQ: begin
            w_rd_o  = 1'b1;
            wait_d  = '0;
            state_d = S_WWAIT;
         end
         S_WWAIT: begin
            if (wait_q == WC_W'(WLAT - 1)) begin
               w_load_o = 1'b1;
               pix_d    = '0;
               state_d  = S_RUN;
            end else begin
               wait_d = wait_q + WC_W'(1);
            end
         end
         S_RUN: begin
            if (win_valid_i) begin
               if (pix_q == cfg_pix_q - PIX_W'(1)) begin
                  state_d = S_DRAIN;
               end else begin
                  pix_d = pix_q + PIX_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (out_q == '0) begin
               if (och_q == cfg_och_q - OCH_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  och_d   = och_q + OCH_W'(1);
                  state_d = S_WREQ;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      out_d = out_q;
      if (ce_in && !ce_out_ok) begin
         out_d = out_q + OUT_W'(1);
      end else if (!ce_in && ce_out_ok && (out_q != '0)) begin
         out_d = out_q - OUT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         och_q     <= '0;
         pix_q     <= '0;
         wait_q    <= '0;
         out_q     <= '0;
         flush_q   <= FL_W'(CE_LAT);
         res_och_q <= '0;
         res_pix_q <= '0;
         err_q     <= 1'b0;
         zdone_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         och_q   <= och_d;
         pix_q   <= pix_d;
         wait_q  <= wait_d;
         out_q   <= out_d;
         zdone_q <= accept && cfg_zero;
         if (flush_q != '0) begin
            flush_q <= flush_q - FL_W'(1);
         end
         if (ce_out_ok && (out_q == '0) && !ce_in) begin
            err_q <= 1'b1;
         end
         if (accept) begin
            res_och_q <= '0;
            res_pix_q <= '0;
         end else if (ce_out_ok) begin
            if (res_pix_q == cfg_pix_q - PIX_W'(1)) begin
               res_pix_q <= '0;
               res_och_q <= res_och_q + OCH_W'(1);
            end else begin
               res_pix_q <= res_pix_q + PIX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         cfg_och_q <= cfg_och_i;
         cfg_pix_q <= cfg_pix_i;
      end
   end

`ifdef CE_SCHED_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (accept) begin
         stall_q <= '0;
      end else if (run_st && !win_valid_i && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`endif

   assign w_addr_o    = w_rd_o ? och_q : '0;
   assign win_ready_o = run_st;
   assign ce_en_in_o  = ce_in;
   assign res_valid_o = ce_out_ok;
   assign res_och_o   = res_och_q;
   assign res_pix_o   = res_pix_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE) || zdone_q;
   assign err_o       = err_q;

endmodule
